// File: rtl/ibex_defines.sv
// Shared types for the eFPGA accelerator controller in the EX stage.
package ibex_defines;

    // Completion style of a fabric operation
    typedef enum logic {
        EFPGA_FIXED     = 1'b0,
        EFPGA_HANDSHAKE = 1'b1
    } efpga_mode_e;

    // Controller sequencing states
    typedef enum logic [1:0] {
        EFPGA_IDLE = 2'd0,
        EFPGA_BUSY = 2'd1,
        EFPGA_DONE = 2'd2
    } efpga_state_e;

    // Counter width wide enough for both the fixed delay and the timeout
    function automatic int efpga_cnt_w(input int delay_w, input int timeout_cyc);
        int to_w;
        to_w = $clog2(timeout_cyc + 1);
        return (delay_w > to_w) ? delay_w : to_w;
    endfunction

endpackage

// File: rtl/ibex_efpga_timer.sv
// Shared saturating counter: counts the fixed delay down, or the handshake
// timeout up. Load/clear have priority over counting.
module ibex_efpga_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         down,
    input  logic         up,
    output logic         zero,
    output logic         expire
);

    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] count;

    // Counter update: clear > load > saturating down > saturating up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (down && count != '0) begin
            count <= count - W'(1);
        end else if (up && count != MAX) begin
            count <= count + W'(1);
        end
    end

    assign zero   = (count == '0);
    // High when the increment taking place this cycle reaches the limit
    assign expire = (count >= MAX - W'(1));

endmodule

// File: rtl/ibex_efpga_ctrl.sv
// eFPGA accelerator controller: launches one fabric operation per EX
// instruction, waits a fixed delay or a valid handshake (with timeout), then
// presents the selected channel result for exactly one cycle.
module ibex_efpga_ctrl
    import ibex_defines::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int DELAY_W     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       kill_i,
    input  logic [$clog2(NUM_CH)-1:0]  operator_i,
    input  logic                       mode_i,
    input  logic [DELAY_W-1:0]         delay_i,
    input  logic [NUM_CH*DATA_W-1:0]   fabric_res_i,
    input  logic                       fabric_valid_i,
    output logic                       fabric_start_o,
    output logic                       ready_o,
    output logic [DATA_W-1:0]          result_o,
    output logic                       err_o
);

    localparam int OP_W  = $clog2(NUM_CH);
    localparam int CNT_W = efpga_cnt_w(DELAY_W, TIMEOUT_CYC);

    efpga_state_e     state;
    efpga_mode_e      mode_q;
    logic [OP_W-1:0]  op_q;

    logic             launch, busy, hs;
    logic             tmr_zero, tmr_expire, tmr_down, tmr_up;
    logic [CNT_W-1:0] tmr_load_val;
    logic             op_ok, cap, cap_err;
    logic [DATA_W-1:0] sel_res, cap_res;

    // Start pulse is gated by reset so the fabric never sees a launch during reset
    assign launch         = rst_n & (state == EFPGA_IDLE) & en_i & ~kill_i;
    assign fabric_start_o = launch;
    assign busy           = (state == EFPGA_BUSY);
    assign hs             = (mode_q == EFPGA_HANDSHAKE);

    // Fixed mode counts the delay down; handshake mode counts elapsed cycles up from 0
    assign tmr_load_val = mode_i ? '0 : CNT_W'(delay_i);
    assign tmr_down     = busy & ~hs & ~kill_i;
    assign tmr_up       = busy & hs & ~fabric_valid_i & ~kill_i;

    ibex_efpga_timer #(
        .W     (CNT_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (kill_i),
        .load     (launch),
        .load_val (tmr_load_val),
        .down     (tmr_down),
        .up       (tmr_up),
        .zero     (tmr_zero),
        .expire   (tmr_expire)
    );

    // Channel mux; out-of-range selects (non power-of-2 NUM_CH) yield 0
    always_comb begin
        sel_res = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (op_q == OP_W'(k)) sel_res = fabric_res_i[k*DATA_W +: DATA_W];
        end
    end

    assign op_ok   = (int'(op_q) < NUM_CH);
    // Valid beats expiry in the same cycle
    assign cap     = hs ? (fabric_valid_i | tmr_expire) : tmr_zero;
    assign cap_err = (hs & ~fabric_valid_i) | ~op_ok;
    assign cap_res = cap_err ? '0 : sel_res;

    // Sequencing FSM with registered ready/result/error; kill overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EFPGA_IDLE;
            mode_q   <= EFPGA_FIXED;
            op_q     <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
            err_o    <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (kill_i) begin
                state <= EFPGA_IDLE;
            end else begin
                unique case (state)
                    EFPGA_IDLE: begin
                        if (en_i) begin
                            op_q   <= operator_i;
                            mode_q <= efpga_mode_e'(mode_i);
                            state  <= EFPGA_BUSY;
                        end
                    end
                    EFPGA_BUSY: begin
                        if (cap) begin
                            state    <= EFPGA_DONE;
                            ready_o  <= 1'b1;
                            result_o <= cap_res;
                            err_o    <= cap_err;
                        end
                    end
                    EFPGA_DONE: state <= EFPGA_IDLE;
                    default:    state <= EFPGA_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ibex_efpga_ctrl.sv
// Bench for ibex_efpga_ctrl: directed scenarios plus randomized operations,
// each checked against a latency/result model derived from the operation rules.
module tb_ibex_efpga_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, kill, mode, fvalid;
    logic [1:0]   op;
    logic [3:0]   dly;
    logic [127:0] fab;

    logic        start_a, ready_a, err_a;
    logic [31:0] res_a;
    logic        start_b, ready_b, err_b;
    logic [31:0] res_b;

    int total = 0;
    int bad   = 0;
    int sel   = 0;   // 0: dut_a (4 ch, timeout 255), 1: dut_b (3 ch, timeout 4)

    always #5 clk = ~clk;

    ibex_efpga_ctrl #(.NUM_CH(4), .DATA_W(32), .DELAY_W(4), .TIMEOUT_CYC(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .en_i(en), .kill_i(kill), .operator_i(op),
        .mode_i(mode), .delay_i(dly), .fabric_res_i(fab), .fabric_valid_i(fvalid),
        .fabric_start_o(start_a), .ready_o(ready_a), .result_o(res_a), .err_o(err_a)
    );

    ibex_efpga_ctrl #(.NUM_CH(3), .DATA_W(32), .DELAY_W(4), .TIMEOUT_CYC(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en_i(en), .kill_i(kill), .operator_i(op),
        .mode_i(mode), .delay_i(dly), .fabric_res_i(fab[95:0]), .fabric_valid_i(fvalid),
        .fabric_start_o(start_b), .ready_o(ready_b), .result_o(res_b), .err_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_start();  return {31'b0, (sel != 0) ? start_b : start_a}; endfunction
    function automatic logic [31:0] o_ready();  return {31'b0, (sel != 0) ? ready_b : ready_a}; endfunction
    function automatic logic [31:0] o_err();    return {31'b0, (sel != 0) ? err_b : err_a};     endfunction
    function automatic logic [31:0] o_result(); return (sel != 0) ? res_b : res_a;               endfunction

    task automatic rnd_fab();
        for (int k = 0; k < 4; k++) fab[k*32 +: 32] = $urandom;
    endtask

    // One operation launched at c=0. m: 0 fixed/1 handshake, d: delay,
    // vat: cycle of fabric valid (-1 none), kat: kill cycle (-1 none), drop: en low in BUSY.
    task automatic run_op(input int m, input int o, input int d, input int vat,
                          input int kat, input bit drop);
        int nch, to, lat, last;
        bit tmo, killed, ee;
        logic [31:0] er;
        nch = (sel != 0) ? 3 : 4;
        to  = (sel != 0) ? 4 : 255;
        if (m == 0)                        lat = d + 2;
        else if (vat >= 1 && vat <= to)    lat = vat + 1;
        else                               lat = to + 1;
        tmo    = (m == 1) && !(vat >= 1 && vat <= to);
        killed = (kat >= 1) && (kat < lat);
        ee     = tmo || (o >= nch);
        er     = ee ? 32'h0 : fab[o*32 +: 32];
        last   = killed ? kat : lat;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            en     = (c == 0) ? 1'b1 : !drop;
            op     = (c == 0) ? 2'(o) : 2'($urandom);
            mode   = (c == 0) ? 1'(m) : 1'($urandom);
            dly    = (c == 0) ? 4'(d) : 4'($urandom);
            kill   = (c == kat);
            fvalid = (m == 1) ? (c == vat) : 1'($urandom);
            #1;
            chk("start", o_start(), {31'b0, c == 0});
            chk("ready", o_ready(), {31'b0, !killed && c == lat});
            if (!killed && c == lat) begin
                chk("result", o_result(), er);
                chk("err", o_err(), {31'b0, ee});
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        en = 1'b0; kill = 1'b0; fvalid = 1'($urandom);
        #1;
        chk("idle_start", o_start(), 32'h0);
        chk("idle_ready", o_ready(), 32'h0);
    endtask

    // Resynchronise both instances to IDLE when switching which one is checked
    task automatic switch_to(input int s);
        @(negedge clk);
        en = 1'b0; kill = 1'b1; fvalid = 1'b0;
        sel = s;
        @(negedge clk);
        kill = 1'b0;
    endtask

    task automatic rnd_ops(input int n, input int max_op, input int max_v);
        int m, vat, kat;
        for (int i = 0; i < n; i++) begin
            rnd_fab();
            m   = $urandom_range(0, 1);
            vat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, max_v);
            kat = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : -1;
            run_op(m, $urandom_range(0, max_op), $urandom_range(0, 15), vat, kat,
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; kill = 1'b0; mode = 1'b0; fvalid = 1'b0;
        op = 2'd0; dly = 4'd0; fab = '0;
        repeat (2) @(negedge clk);
        #1;
        // Reset state of both instances (en high: start must still be held off)
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk("rst_start", o_start(), 32'h0);
            chk("rst_ready", o_ready(), 32'h0);
            chk("rst_result", o_result(), 32'h0);
            chk("rst_err", o_err(), 32'h0);
        end
        sel = 0;
        en  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        // Fixed delay 3, channel 2
        rnd_fab(); fab[2*32 +: 32] = 32'hDEADBEEF;
        run_op(0, 2, 3, -1, -1, 1'b0);
        idle_cycle();

        // Fixed delay 0, back-to-back with en held
        rnd_fab();
        run_op(0, 1, 0, -1, -1, 1'b0);
        run_op(0, 3, 0, -1, -1, 1'b0);
        idle_cycle();

        // Handshake, valid 7 cycles after start
        rnd_fab(); fab[1*32 +: 32] = 32'h12345678;
        run_op(1, 1, 0, 7, -1, 1'b0);

        // Kill in second BUSY cycle with concurrent valid, then an op straight after
        rnd_fab();
        run_op(1, 0, 0, 2, 2, 1'b0);
        run_op(0, 2, 2, -1, -1, 1'b1);
        idle_cycle();

        rnd_ops(30, 3, 12);

        // Timeout instance: expiry, valid on expiry cycle, invalid channel
        switch_to(1);
        rnd_fab();
        run_op(1, 1, 0, -1, -1, 1'b0);
        run_op(1, 2, 0, 4, -1, 1'b0);
        run_op(1, 0, 0, 5, -1, 1'b0);
        run_op(0, 3, 2, -1, -1, 1'b0);
        idle_cycle();
        rnd_ops(30, 3, 6);

        // Asynchronous reset mid-BUSY after a completed op left non-zero outputs
        switch_to(0);
        rnd_fab(); fab[0 +: 32] = 32'hA5A5A5A5;
        run_op(0, 0, 1, -1, -1, 1'b0);
        @(negedge clk);
        en = 1'b1; op = 2'd1; mode = 1'b0; dly = 4'd10; kill = 1'b0; fvalid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", o_start(), 32'h0);
        chk("arst_ready", o_ready(), 32'h0);
        chk("arst_result", o_result(), 32'h0);
        chk("arst_err", o_err(), 32'h0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        rnd_fab();
        run_op(0, 1, 1, -1, -1, 1'b0);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
